// File: rtl/vga_pkg.sv
// Shared constants and FSM state encoding for the VGA write scheduler.
package vga_pkg;

  localparam int X_MAX        = 159;
  localparam int Y_MAX        = 119;
  localparam int COLOR_W      = 12;
  localparam int CLEAR_PIXELS = (X_MAX + 1) * (Y_MAX + 1);
  localparam int CNT_W        = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

endpackage

// File: rtl/vga_pixel_reg.sv
// Output register stage for the adapter's pixel port.
// Draw beats outside the visible frame are swallowed and reported through drop.
module vga_pixel_reg #(
  parameter int X_MAX   = vga_pkg::X_MAX,
  parameter int Y_MAX   = vga_pkg::Y_MAX,
  parameter int COLOR_W = vga_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_check,
  input  logic [7:0]         in_x,
  input  logic [7:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic [7:0]         vga_x,
  output logic [7:0]         vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               drop
);

  import vga_pkg::*;

  logic               in_range;
  logic               plot_d, plot_q;
  logic [7:0]         x_d, x_q;
  logic [7:0]         y_d, y_q;
  logic [COLOR_W-1:0] color_d, color_q;

  always_comb begin
    in_range = (in_x <= 8'(X_MAX)) && (in_y <= 8'(Y_MAX));
    plot_d   = in_valid && (!in_check || in_range);
    drop     = in_valid && in_check && !in_range;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    // Coordinates only move on a real plot so the adapter sees stable values otherwise.
    if (plot_d) begin
      x_d     = in_x;
      y_d     = in_y;
      color_d = in_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign vga_x     = x_q;
  assign vga_y     = y_q;
  assign vga_color = color_q;
  assign vga_plot  = plot_q;

endmodule

// File: rtl/vga_write_scheduler.sv
// Arbitrates the adapter's single pixel-write port between the clear engine
// and the draw engine: one exclusive full-frame clear, then draw traffic.
module vga_write_scheduler #(
  parameter int X_MAX        = vga_pkg::X_MAX,
  parameter int Y_MAX        = vga_pkg::Y_MAX,
  parameter int COLOR_W      = vga_pkg::COLOR_W,
  parameter int CLEAR_PIXELS = vga_pkg::CLEAR_PIXELS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_clear,
  input  logic               clr_valid,
  output logic               clr_ready,
  input  logic [7:0]         clr_x,
  input  logic [7:0]         clr_y,
  input  logic [COLOR_W-1:0] clr_color,
  input  logic               drw_valid,
  output logic               drw_ready,
  input  logic [7:0]         drw_x,
  input  logic [7:0]         drw_y,
  input  logic [COLOR_W-1:0] drw_color,
  output logic [7:0]         vga_x,
  output logic [7:0]         vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               clearing,
  output logic               clear_done,
  output logic               drop_sticky
);

  import vga_pkg::*;

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   clr_cnt_d, clr_cnt_q;
  logic               clear_done_d, clear_done_q;
  logic               drop_sticky_d, drop_sticky_q;

  logic               clr_beat;
  logic               drw_beat;
  logic               last_beat;
  logic               sel_draw;
  logic               pix_valid;
  logic [7:0]         pix_x;
  logic [7:0]         pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_drop;

  // Readies come from registered state only, so no valid-to-ready path exists.
  assign clr_ready = (state_q == ST_CLEAR);
  assign drw_ready = (state_q == ST_DRAW);
  assign clearing  = (state_q == ST_CLEAR);

  assign clr_beat  = clr_valid && clr_ready;
  assign drw_beat  = drw_valid && drw_ready;
  assign last_beat = (clr_cnt_q == CNT_W'(CLEAR_PIXELS - 1));

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    clear_done_d  = 1'b0;
    drop_sticky_d = drop_sticky_q;

    case (state_q)
      ST_IDLE: begin
        if (start_clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_beat) begin
          if (last_beat) begin
            state_d      = ST_DRAW;
            clr_cnt_d    = '0;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAW: begin
        if (start_clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase

    // A drop in the same cycle as start_clear is still recorded.
    if (start_clear) drop_sticky_d = 1'b0;
    if (pix_drop)    drop_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= '0;
      clear_done_q  <= 1'b0;
      drop_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      clear_done_q  <= clear_done_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

  assign clear_done  = clear_done_q;
  assign drop_sticky = drop_sticky_q;

  always_comb begin
    sel_draw  = (state_q == ST_DRAW);
    pix_valid = sel_draw ? drw_beat  : clr_beat;
    pix_x     = sel_draw ? drw_x     : clr_x;
    pix_y     = sel_draw ? drw_y     : clr_y;
    pix_color = sel_draw ? drw_color : clr_color;
  end

  vga_pixel_reg #(
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX),
    .COLOR_W (COLOR_W)
  ) u_pixel_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pix_valid),
    .in_check  (sel_draw),
    .in_x      (pix_x),
    .in_y      (pix_y),
    .in_color  (pix_color),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_color (vga_color),
    .vga_plot  (vga_plot),
    .drop      (pix_drop)
  );

endmodule

// File: doc/vga_write_scheduler.md
# vga_write_scheduler

Schedules the single pixel-write port of the VGA frame adapter between two requesters. The requesters are the background clear engine, which streams 160x120 pixels from the background RAM, and the sprite/draw engine. On command it runs one exclusive full-frame clear, hands the port to the draw engine, and registers the winning pixel onto the adapter's x/y/colour/plot inputs. It also generates the clear engine's `lock` advance-enable.

## Interface
Parameters:
- `X_MAX`, default 159: last valid column.
- `Y_MAX`, default 119: last valid row.
- `COLOR_W`, default 12: colour width.
- `CLEAR_PIXELS`, default 19200: beats per full clear, equal to (X_MAX+1)*(Y_MAX+1).

Ports:
- `clk`, in, 1: single clock, all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `start_clear`, in, 1: single-cycle request to begin a full-frame clear.
- `clr_valid`, in, 1: clear engine pixel valid.
- `clr_ready`, out, 1: clear engine advance-enable; drives its `lock`.
- `clr_x`, in, 8: clear engine column.
- `clr_y`, in, 8: clear engine row.
- `clr_color`, in, COLOR_W: clear engine colour.
- `drw_valid`, in, 1: draw engine pixel valid.
- `drw_ready`, out, 1: draw engine accept.
- `drw_x`, in, 8: draw engine column.
- `drw_y`, in, 8: draw engine row.
- `drw_color`, in, COLOR_W: draw engine colour.
- `vga_x`, out, 8: registered pixel column to the adapter.
- `vga_y`, out, 8: registered pixel row to the adapter.
- `vga_color`, out, COLOR_W: registered pixel colour to the adapter.
- `vga_plot`, out, 1: adapter write strobe.
- `clearing`, out, 1: high while in CLEAR.
- `clear_done`, out, 1: one-cycle pulse after the last clear beat.
- `drop_sticky`, out, 1: set when a draw beat is out of range; cleared by reset or `start_clear`.

## Operation
- FSM states: IDLE, CLEAR, DRAW. Reset enters IDLE.
- IDLE: `clr_ready`=0, `drw_ready`=0. `start_clear` moves to CLEAR.
- CLEAR: `clr_ready`=1, `drw_ready`=0.
  - A beat is `clr_valid & clr_ready`.
  - Each beat increments the 15-bit `clr_cnt`.
  - The beat with `clr_cnt == CLEAR_PIXELS-1` moves the FSM to DRAW, zeroes `clr_cnt`, and pulses `clear_done` on the next cycle.
  - `start_clear` is ignored in CLEAR and does not restart the count.
- DRAW: `drw_ready`=1, `clr_ready`=0.
  - A beat is `drw_valid & drw_ready`.
  - `start_clear` moves to CLEAR. A draw beat in that same cycle is still accepted and plotted.
- Range check, draw beats only: if `drw_x > X_MAX` or `drw_y > Y_MAX`, the beat is accepted (ready honoured) but not plotted, and `drop_sticky` is set.
- Clear beats are not range-checked.
- `clr_cnt` is visible only through state transitions; it is not a port.

## Timing
- Output register: an accepted, in-range beat in cycle N gives `vga_x`, `vga_y`, `vga_color` = beat values and `vga_plot`=1 in cycle N+1. Latency is 1 cycle.
- `vga_plot` is 0 in every cycle not following an accepted in-range beat. `vga_x`, `vga_y`, `vga_color` hold their last values when `vga_plot`=0.
- `clr_ready` and `drw_ready` are functions of registered state only, with no combinational path from any valid input. They are never both 1.
- CLEAR to DRAW: the cycle after the final clear beat already has `drw_ready`=1. There is no bubble.
- Reset values: state IDLE, `clr_cnt`=0, all outputs 0.
- Reset mid-clear: everything is aborted and `clear_done` is not pulsed. A new `start_clear` restarts from count 0. The clear engine is reset on the same `reset`.
- If `clr_valid` is low in CLEAR, the count stalls. There is no timeout.

## Structure
- The shared package `vga_pkg` holds `X_MAX`, `Y_MAX`, `COLOR_W`, `CLEAR_PIXELS` and the state enum (`ST_IDLE`, `ST_CLEAR`, `ST_DRAW`).
- One sub-module, `vga_pixel_reg`: the output register stage plus range check, instantiated once behind the mux.
- FSM and `clr_cnt` live in the top.

## Test plan
- Reset then no `start_clear`, with both valids held high for 50 cycles -> both readies 0, `vga_plot` never 1.
- `start_clear`, clear engine streams 19200 beats (0,0)..(159,119) -> exactly 19200 `vga_plot` pulses, each 1 cycle after its beat. `clear_done` pulses once, the cycle after beat 19200. `drw_ready`=1 in that same cycle.
- Clear with `clr_valid` toggling every other cycle -> still exactly 19200 plots. The transition waits for the 19200th beat.
- In DRAW, beat (10,20,0xF00) then (200,5,0x0F0) -> one plot with x=10, y=20, colour 0xF00. The second beat is accepted and dropped, and `drop_sticky`=1.
- In DRAW, `start_clear` with a coincident draw beat (3,4) -> (3,4) plotted next cycle. `clr_ready`=1 and `drw_ready`=0 from the next cycle. `drop_sticky` cleared.
- `reset` asserted after 5000 clear beats, then `start_clear` -> no `clear_done` from the aborted clear. The new clear needs a full 19200 beats.
